spi_master_core: RTL
====================

// Module: spi_master_core
// PURPOSE
//  Parametrised full-duplex SPI master, successor to the fixed 8-bit mode-0 shifter.
//  Adds word width, a runtime clock divider, CPOL/CPHA/bit-order selection, an owned chip select
//  with multi-word framing, receive capture, and a valid/ready transmit handshake.
//  Sits between the CPU's memory-mapped SPI registers and the external pads.
// PARAMETERS
//  DATA_W  8  bits per transfer word (>=2)
//  DIV_W   8  width of cfg_div; half-period H = cfg_div+1 clk cycles
// PORTS
//  clk            in   1       system clock
//  rst            in   1       synchronous reset, active-high
//  cfg_cpol       in   1       idle level of spi_clk
//  cfg_cpha       in   1       0: sample on leading edge; 1: sample on trailing edge
//  cfg_lsb_first  in   1       1: LSB shifted first on MOSI and MISO
//  cfg_div        in   DIV_W   half-period select
//  tx_data        in   DATA_W  word to send
//  tx_last        in   1       release CS after this word
//  tx_valid       in   1       tx_data/tx_last valid
//  tx_ready       out  1       block can accept a word
//  rx_data        out  DATA_W  last received word; held until the next word completes
//  rx_valid       out  1       one-cycle pulse: rx_data updated
//  busy           out  1       high whenever cs_n is low
//  spi_clk        out  1       serial clock
//  spi_mosi       out  1       serial data out
//  spi_miso       in   1       serial data in
//  spi_cs_n       out  1       chip select, active-low
// BEHAVIOUR
//  Reset values (cycle after rst high): spi_cs_n=1, spi_clk=0, spi_mosi=0, rx_data=0,
//   rx_valid=0, busy=0, tx_ready=0 while rst high, state=IDLE. Reset aborts any word at once,
//   with no rx_valid.
//  Outputs:
//   - All outputs are registered except tx_ready, which is high in IDLE and GAP.
//   - busy is high whenever spi_cs_n is low.
//  Accept = tx_valid & tx_ready.
//   - Latches tx_data, tx_last, cpol, cpha, lsb_first and div.
//   - cfg_* changes after accept have no effect until the next accept.
//  States:
//   IDLE:  cs_n=1; spi_clk follows cfg_cpol (registered). Accept -> SETUP; cs_n=0 next cycle.
//   SETUP: H cycles. If cpha=0, first bit is driven on MOSI when cs_n falls. Then -> XFER.
//   XFER:  2*DATA_W spi_clk toggles, one every H cycles; the first toggle is H cycles after
//          cs_n falls.
//          - Sample edge: MISO registered in the same clk that spi_clk toggles.
//          - Shift edge: next MOSI bit driven.
//          - cpha=0: leading edge samples, trailing edge shifts.
//          - cpha=1: leading edge shifts (first bit), trailing edge samples.
//          After the final toggle:
//          - rx_data is updated and rx_valid pulses on the next cycle.
//          - Go to HOLD if latched last=1, else to GAP.
//   GAP:   cs_n stays 0 and spi_clk stays idle; tx_ready=1.
//          - Accept -> SETUP (new word and config).
//          - No cs release without a word marked last.
//   HOLD:  H cycles with cs_n=0, then cs_n=1 -> IDLE.
//  Bit order and timing:
//   - rx_data is assembled in the same bit order as transmit.
//   - Single word, tx_last=1: cs_n low for exactly (2*DATA_W+2)*H cycles.
//  Boundary conditions:
//   - cfg_div=0 means one clk per half-period; all-ones means 2^DIV_W.
//   - tx_valid while busy and not in GAP: word held off, no loss.
//   - tx_valid held high: accepted on the first IDLE/GAP cycle.
// TESTING
//  1. Mode 0, div=0, tx 0xA5 last=1, MISO drives 0x3C MSB-first -> MOSI 1,0,1,0,0,1,0,1 at rising
//     edges; rx_data=0x3C; single rx_valid; cs_n low 18 cycles.
//  2. Mode 3, div=3, lsb_first, tx 0x01 -> spi_clk idles 1, 4-cycle half-periods; MOSI first bit 1
//     driven at first (falling) edge; rx sampled on rising edges.
//  3. Two words 0x12 (last=0) then 0x34 (last=1), tx_valid held -> cs_n low continuously across
//     both; two rx_valid pulses; cs_n high after second HOLD.
//  4. rst asserted after 5 toggles -> next cycle cs_n=1, spi_clk=0, no rx_valid; then a fresh word
//     completes normally.
//  5. cfg_div and cfg_cpol changed mid-word -> current word timing/polarity unchanged; next word
//     uses new values.
//  6. DATA_W=16, tx 0xBEEF loopback (MISO=MOSI) -> rx_data=0xBEEF in both mode 0 and mode 1.

Source files
------------

// File: rtl/spi_master_core.sv
// spi_master_core: parametrised CPOL/CPHA SPI master with owned chip select, multi-word framing and valid/ready transmit
module spi_master_core #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_cpol_i,
    input  logic              cfg_cpha_i,
    input  logic              cfg_lsb_first_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_last_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              busy_o,
    output logic              spi_clk_o,
    output logic              spi_mosi_o,
    input  logic              spi_miso_i,
    output logic              spi_cs_n_o
);
    localparam int TW = $clog2(2 * DATA_W + 1);
    localparam logic [TW-1:0] LAST_TOG = TW'(2 * DATA_W);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, GAP, HOLD} state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
    logic [TW-1:0]     tog_q, tog_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, tx_nxt;
    logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, last_q, last_d;
    logic              sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d, busy_q, rx_valid_q, fin_q, fin_d;
    logic              accept, tick, do_tog, samp;

    function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
        return lsb ? d[0] : d[DATA_W-1];
    endfunction

    assign tx_ready_o = ~rst & (state_q == IDLE || state_q == GAP);
    assign accept     = tx_valid_i & tx_ready_o;
    assign tick       = cnt_q == '0;
    assign do_tog     = tick & (state_q == SETUP || (state_q == XFER && tog_q != LAST_TOG));
    // odd-numbered toggles are leading edges; cpha swaps which edge samples
    assign samp       = ~tog_q[0] ^ cpha_q;
    assign tx_nxt     = lsb_q ? tx_sh_q >> 1 : tx_sh_q << 1;

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? div_q : cnt_q - DIV_W'(1);
        div_d   = div_q;
        tog_d   = tog_q;
        tx_sh_d = tx_sh_q;
        rx_sh_d = rx_sh_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        lsb_d   = lsb_q;
        last_d  = last_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        fin_d   = do_tog && tog_q == LAST_TOG - TW'(1);
        if (do_tog) begin
            sclk_d = ~sclk_q;
            tog_d  = tog_q + TW'(1);
            if (samp) begin
                rx_sh_d = lsb_q ? {spi_miso_i, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], spi_miso_i};
            end else begin
                tx_sh_d = tx_nxt;
                mosi_d  = cpha_q ? first_bit(tx_sh_q, lsb_q) : first_bit(tx_nxt, lsb_q);
            end
        end
        case (state_q)
            IDLE:    sclk_d = cfg_cpol_i;
            SETUP:   state_d = tick ? XFER : SETUP;
            XFER:    state_d = (tick && tog_q == LAST_TOG) ? (last_q ? HOLD : GAP) : XFER;
            GAP:     sclk_d = cpol_q;
            HOLD: begin
                sclk_d  = cpol_q;
                state_d = tick ? IDLE : HOLD;
                cs_n_d  = tick | cs_n_q;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = SETUP;
            cs_n_d  = 1'b0;
            cnt_d   = cfg_div_i;
            div_d   = cfg_div_i;
            tog_d   = '0;
            tx_sh_d = tx_data_i;
            cpol_d  = cfg_cpol_i;
            cpha_d  = cfg_cpha_i;
            lsb_d   = cfg_lsb_first_i;
            last_d  = tx_last_i;
            sclk_d  = cfg_cpol_i;
            mosi_d  = cfg_cpha_i ? mosi_q : first_bit(tx_data_i, cfg_lsb_first_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            tog_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            last_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            fin_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            tog_q      <= tog_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= fin_q ? rx_sh_q : rx_data_q;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            last_q     <= last_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= ~cs_n_d;
            rx_valid_q <= fin_q;
            fin_q      <= fin_d;
        end
    end

    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = busy_q;
    assign spi_clk_o  = sclk_q;
    assign spi_mosi_o = mosi_q;
    assign spi_cs_n_o = cs_n_q;
endmodule
